// File: rtl/ap_mon_pkg.sv
// rtl/ap_mon_pkg.sv - shared channel state and record types for ap_ctrl_perf_mon
`ifndef AP_MON_PKG_SV
`define AP_MON_PKG_SV

// Record layout; instantiated with the channel-index and timestamp widths of the user
`define AP_MON_PERF_REC_T(CHW, TSW) struct packed { logic [(CHW)-1:0] ch; logic [(TSW)-1:0] start_ts; logic [(TSW)-1:0] latency; logic [(TSW)-1:0] interval; }

package ap_mon_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } ch_state_e;

  localparam int DEF_N_CH = 4;
  localparam int DEF_TS_W = 32;

  // Channel index width, never narrower than one bit
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef `AP_MON_PERF_REC_T(ch_idx_w(DEF_N_CH), DEF_TS_W) perf_rec_t;

endpackage

`endif

// File: rtl/mon_rec_fifo.sv
// rtl/mon_rec_fifo.sv - first-word-fall-through record FIFO
module mon_rec_fifo
  import ap_mon_pkg::*;
#(
  parameter type rec_t = perf_rec_t,
  parameter int  DEPTH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  rec_t push_data,
  output logic full,
  input  logic pop,
  output rec_t pop_data,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  rec_t           mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; a pop frees the slot that a simultaneous push may reuse
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are only visible through the pointers, so no reset
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ap_ctrl_perf_mon.sv
// rtl/ap_ctrl_perf_mon.sv - multi-channel ap_ctrl transaction profiler; MONITOR_DEADLOCK_EN adds watchdogs
module ap_ctrl_perf_mon
  import ap_mon_pkg::*;
#(
  parameter int  N_CH       = 4,
  parameter int  TS_W       = 32,
  parameter int  FIFO_DEPTH = 16,
  parameter int  WDOG_LIMIT = 1000000,
  localparam int CH_W       = ch_idx_w(N_CH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            finish,
  input  logic [N_CH-1:0] ap_start,
  input  logic [N_CH-1:0] ap_ready,
  input  logic [N_CH-1:0] ap_done,
  input  logic [N_CH-1:0] ap_continue,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [CH_W-1:0] rec_ch,
  output logic [TS_W-1:0] rec_start_ts,
  output logic [TS_W-1:0] rec_latency,
  output logic [TS_W-1:0] rec_interval,
  output logic            overflow,
  output logic            drained,
  output logic [N_CH-1:0] deadlock
);

  typedef `AP_MON_PERF_REC_T(CH_W, TS_W) rec_t;

  logic [TS_W-1:0] ts;
  ch_state_e       state        [N_CH];
  logic [TS_W-1:0] start_ts_r   [N_CH];
  logic [TS_W-1:0] prev_start_r [N_CH];
  logic [TS_W-1:0] interval_r   [N_CH];
  logic [TS_W-1:0] latency_r    [N_CH];
  logic [N_CH-1:0] first;

  logic [N_CH-1:0] accept;
  logic [N_CH-1:0] prod;
  logic [TS_W-1:0] start_itv    [N_CH];
  rec_t            prod_rec     [N_CH];

  logic [N_CH-1:0] hold_valid;
  rec_t            hold_rec     [N_CH];
  logic            sel_valid;
  logic [CH_W-1:0] sel_idx;
  logic            push_ok;
  logic [N_CH-1:0] drain;

  logic            finish_seen;
  logic            stop;
  logic            all_idle;

  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  rec_t            fifo_out;

  // ap_ready carries no information the FSM needs
  logic            unused_ready;
  assign unused_ready = &ap_ready;

  assign stop = finish || finish_seen;

  // Free-running timestamp, wraps modulo 2^TS_W
  always_ff @(posedge clock) begin
    if (reset) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  // Decide which channels start or complete a transaction this cycle
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      accept[i]      = (state[i] == IDLE) && ap_start[i] && !stop;
      start_itv[i]   = first[i] ? '0 : ts - prev_start_r[i];
      prod[i]        = 1'b0;
      prod_rec[i]    = '0;
      prod_rec[i].ch = CH_W'(i);
      case (state[i])
        IDLE: begin
          if (accept[i] && ap_done[i] && ap_continue[i]) begin
            prod[i]              = 1'b1;
            prod_rec[i].start_ts = ts;
            prod_rec[i].interval = start_itv[i];
          end
        end
        BUSY: begin
          if (ap_done[i] && ap_continue[i]) begin
            prod[i]              = 1'b1;
            prod_rec[i].start_ts = start_ts_r[i];
            prod_rec[i].latency  = ts - start_ts_r[i];
            prod_rec[i].interval = interval_r[i];
          end
        end
        DONE_WAIT: begin
          if (ap_continue[i]) begin
            prod[i]              = 1'b1;
            prod_rec[i].start_ts = start_ts_r[i];
            prod_rec[i].latency  = latency_r[i];
            prod_rec[i].interval = interval_r[i];
          end
        end
        default: ;
      endcase
    end
  end

  // Per-channel transaction FSM; latency is frozen at the first done cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      first <= '1;
      for (int i = 0; i < N_CH; i++) begin
        state[i]        <= IDLE;
        start_ts_r[i]   <= '0;
        prev_start_r[i] <= '0;
        interval_r[i]   <= '0;
        latency_r[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        case (state[i])
          IDLE: begin
            if (accept[i]) begin
              start_ts_r[i]   <= ts;
              prev_start_r[i] <= ts;
              interval_r[i]   <= start_itv[i];
              first[i]        <= 1'b0;
              if (ap_done[i]) begin
                latency_r[i] <= '0;
                state[i]     <= ap_continue[i] ? IDLE : DONE_WAIT;
              end else begin
                state[i] <= BUSY;
              end
            end
          end
          BUSY: begin
            if (ap_done[i]) begin
              latency_r[i] <= ts - start_ts_r[i];
              state[i]     <= ap_continue[i] ? IDLE : DONE_WAIT;
            end
          end
          DONE_WAIT: begin
            if (ap_continue[i]) state[i] <= IDLE;
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  // Fixed-priority pick of the lowest occupied holding register
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (hold_valid[i]) begin
        sel_valid = 1'b1;
        sel_idx   = CH_W'(i);
      end
    end
  end

  assign fifo_pop = !fifo_empty && rec_ready;
  assign push_ok  = sel_valid && (!fifo_full || fifo_pop);

  // Flag which holding register empties into the FIFO this cycle
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      drain[i] = push_ok && (sel_idx == CH_W'(i));
    end
  end

  // Holding registers; a draining register can be reloaded in the same cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < N_CH; i++) hold_rec[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (prod[i]) begin
          if (hold_valid[i] && !drain[i]) begin
            overflow <= 1'b1;
          end else begin
            hold_valid[i] <= 1'b1;
            hold_rec[i]   <= prod_rec[i];
          end
        end else if (drain[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  mon_rec_fifo #(
    .rec_t (rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_ok),
    .push_data (hold_rec[sel_idx]),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .empty     (fifo_empty)
  );

  assign rec_valid    = !fifo_empty;
  assign rec_ch       = rec_valid ? fifo_out.ch       : '0;
  assign rec_start_ts = rec_valid ? fifo_out.start_ts : '0;
  assign rec_latency  = rec_valid ? fifo_out.latency  : '0;
  assign rec_interval = rec_valid ? fifo_out.interval : '0;

  // Every channel parked in IDLE
  always_comb begin
    all_idle = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (state[i] != IDLE) all_idle = 1'b0;
    end
  end

  // Remember finish and raise drained once nothing is left in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      finish_seen <= 1'b0;
      drained     <= 1'b0;
    end else begin
      finish_seen <= finish_seen || finish;
      if (stop && all_idle && (hold_valid == '0) && fifo_empty) drained <= 1'b1;
    end
  end

`ifdef MONITOR_DEADLOCK_EN
  localparam logic [TS_W-1:0] WD_LIM = TS_W'(WDOG_LIMIT);

  logic [TS_W-1:0] wd_cnt [N_CH];
  logic [TS_W-1:0] wd_nxt [N_CH];
  logic [N_CH-1:0] wd_active;
  logic [N_CH-1:0] deadlock_r;

  // Count cycles spent outside IDLE; the start cycle itself counts as the first
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      wd_active[i] = ((state[i] != IDLE) || accept[i]) && !prod[i];
      if (!wd_active[i])           wd_nxt[i] = '0;
      else if (state[i] == IDLE)   wd_nxt[i] = TS_W'(1);
      else if (wd_cnt[i] == WD_LIM) wd_nxt[i] = wd_cnt[i];
      else                         wd_nxt[i] = wd_cnt[i] + 1'b1;
    end
  end

  // Watchdog counters and sticky deadlock flags
  always_ff @(posedge clock) begin
    if (reset) begin
      deadlock_r <= '0;
      for (int i = 0; i < N_CH; i++) wd_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        wd_cnt[i] <= wd_nxt[i];
        if (wd_active[i] && (wd_nxt[i] == WD_LIM)) deadlock_r[i] <= 1'b1;
      end
    end
  end

  assign deadlock = deadlock_r;
`else
  localparam int unused_wdog_limit = WDOG_LIMIT;
  assign deadlock = '0;
`endif

endmodule

// File: tb/tb_ap_ctrl_perf_mon.sv
// tb/tb_ap_ctrl_perf_mon.sv - scoreboard bench for ap_ctrl_perf_mon
module tb_ap_ctrl_perf_mon;

  localparam int N_CH = 4;
  localparam int TS_W = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            finish = 1'b0;
  logic [N_CH-1:0] ap_start = '0;
  logic [N_CH-1:0] ap_ready = '0;
  logic [N_CH-1:0] ap_done = '0;
  logic [N_CH-1:0] ap_continue = '1;
  logic            rec_ready = 1'b1;
  logic            rec_valid;
  logic [1:0]      rec_ch;
  logic [TS_W-1:0] rec_start_ts;
  logic [TS_W-1:0] rec_latency;
  logic [TS_W-1:0] rec_interval;
  logic            overflow;
  logic            drained;
  logic [N_CH-1:0] deadlock;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] st;
    logic [31:0] lat;
    logic [31:0] itv;
    int          arr;
  } exp_t;

  exp_t        sb[$];
  exp_t        got_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] tb_ts;

  ap_ctrl_perf_mon #(
    .N_CH       (N_CH),
    .TS_W       (TS_W),
    .FIFO_DEPTH (2),
    .WDOG_LIMIT (50)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .finish       (finish),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .ap_continue  (ap_continue),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_ch       (rec_ch),
    .rec_start_ts (rec_start_ts),
    .rec_latency  (rec_latency),
    .rec_interval (rec_interval),
    .overflow     (overflow),
    .drained      (drained),
    .deadlock     (deadlock)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) tb_ts <= 0;
    else       tb_ts <= tb_ts + 1;
  end

  always @(negedge clock) begin
    if (!reset && rec_valid && rec_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record ch=%0d st=%0d lat=%0d int=%0d at ts=%0d, required none",
                 rec_ch, rec_start_ts, rec_latency, rec_interval, tb_ts);
      end else begin
        got_e = sb.pop_front();
        if (rec_ch !== got_e.ch || rec_start_ts !== got_e.st || rec_latency !== got_e.lat ||
            rec_interval !== got_e.itv || (got_e.arr >= 0 && tb_ts !== 32'(got_e.arr))) begin
          errors++;
          $display("FAIL record got ch=%0d st=%0d lat=%0d int=%0d ts=%0d required ch=%0d st=%0d lat=%0d int=%0d ts=%0d",
                   rec_ch, rec_start_ts, rec_latency, rec_interval, tb_ts,
                   got_e.ch, got_e.st, got_e.lat, got_e.itv, got_e.arr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ts(input int v);
    int n = 0;
    while (tb_ts != 32'(v) && n < 2000) begin
      tick();
      n++;
    end
    if (tb_ts != 32'(v)) begin
      checks++;
      errors++;
      $display("FAIL wait_ts got %0d required %0d", tb_ts, v);
    end
  endtask

  task automatic expect_rec(input int ch, input int st, input int lat, input int itv, input int arr);
    exp_t e;
    e.ch  = ch[1:0];
    e.st  = st;
    e.lat = lat;
    e.itv = itv;
    e.arr = arr;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset       = 1'b1;
    finish      = 1'b0;
    ap_start    = '0;
    ap_done     = '0;
    ap_continue = '1;
    rec_ready   = 1'b1;
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_sb_empty(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s pending_records got %0d required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    wait_ts(2);
    checks++;
    if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_rec_valid got %0b required 0", rec_valid); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b required 0", overflow); end
    checks++;
    if (drained !== 1'b0) begin errors++; $display("FAIL reset_drained got %0b required 0", drained); end
    checks++;
    if (deadlock !== 4'b0) begin errors++; $display("FAIL reset_deadlock got %b required 0000", deadlock); end
    checks++;
    if (rec_latency !== 32'd0) begin errors++; $display("FAIL reset_rec_latency got %0d required 0", rec_latency); end
  endtask

  task automatic test_single();
    do_reset();
    wait_ts(5);
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    wait_ts(12);
    ap_done[0] = 1'b1;
    expect_rec(0, 5, 7, 0, 14);
    tick();
    ap_done[0] = 1'b0;
    wait_ts(19);
    checks++;
    if (drained !== 1'b0) begin errors++; $display("FAIL drained_early got %0b required 0", drained); end
    wait_ts(20);
    finish = 1'b1;
    wait_ts(22);
    checks++;
    if (drained !== 1'b1) begin errors++; $display("FAIL drained got %0b required 1", drained); end
    wait_ts(23);
    ap_start[0] = 1'b1;
    ap_done[0]  = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    ap_done[0]  = 1'b0;
    wait_ts(30);
    checks++;
    if (rec_valid !== 1'b0) begin errors++; $display("FAIL start_after_finish got rec_valid %0b required 0", rec_valid); end
    check_sb_empty("single");
  endtask

  task automatic test_back_to_back();
    do_reset();
    wait_ts(10);
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    wait_ts(14);
    ap_done[0] = 1'b1;
    expect_rec(0, 10, 4, 0, 16);
    tick();
    ap_done[0] = 1'b0;
    wait_ts(30);
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    wait_ts(34);
    ap_done[0] = 1'b1;
    expect_rec(0, 30, 4, 20, 36);
    tick();
    ap_done[0] = 1'b0;
    check_sb_empty("back_to_back");
  endtask

  task automatic test_done_wait();
    do_reset();
    ap_continue[1] = 1'b0;
    wait_ts(5);
    ap_start[1] = 1'b1;
    tick();
    ap_start[1] = 1'b0;
    wait_ts(20);
    ap_done[1] = 1'b1;
    tick();
    ap_done[1] = 1'b0;
    wait_ts(25);
    ap_continue[1] = 1'b1;
    expect_rec(1, 5, 15, 0, 27);
    wait_ts(26);
    checks++;
    if (rec_valid !== 1'b0) begin errors++; $display("FAIL done_wait_early got rec_valid %0b required 0", rec_valid); end
    check_sb_empty("done_wait");
  endtask

  task automatic test_all_channels();
    do_reset();
    wait_ts(3);
    ap_start = 4'hF;
    tick();
    ap_start = 4'h0;
    wait_ts(10);
    ap_done = 4'hF;
    for (int c = 0; c < N_CH; c++) expect_rec(c, 3, 7, 0, 12 + c);
    tick();
    ap_done = 4'h0;
    check_sb_empty("all_channels");
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL all_channels_overflow got %0b required 0", overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    rec_ready = 1'b0;
    wait_ts(5);
    ap_start[0] = 1'b1;
    ap_done[0]  = 1'b1;
    expect_rec(0, 5, 0, 0, -1);
    expect_rec(0, 6, 0, 1, -1);
    expect_rec(0, 7, 0, 1, -1);
    wait_ts(8);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_early got %0b required 0", overflow); end
    tick();
    ap_start[0] = 1'b0;
    ap_done[0]  = 1'b0;
    wait_ts(10);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow got %0b required 1", overflow); end
    checks++;
    if (rec_valid !== 1'b1) begin errors++; $display("FAIL overflow_rec_valid got %0b required 1", rec_valid); end
    wait_ts(12);
    rec_ready = 1'b1;
    wait_ts(20);
    check_sb_empty("overflow");
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %0b required 1", overflow); end
  endtask

  task automatic test_deadlock();
    do_reset();
    wait_ts(5);
    ap_start[2] = 1'b1;
    tick();
    ap_start[2] = 1'b0;
`ifdef MONITOR_DEADLOCK_EN
    wait_ts(54);
    checks++;
    if (deadlock !== 4'b0000) begin errors++; $display("FAIL deadlock_early got %b required 0000", deadlock); end
    wait_ts(55);
    checks++;
    if (deadlock !== 4'b0100) begin errors++; $display("FAIL deadlock_set got %b required 0100", deadlock); end
`else
    wait_ts(60);
    checks++;
    if (deadlock !== 4'b0000) begin errors++; $display("FAIL deadlock_disabled got %b required 0000", deadlock); end
`endif
    wait_ts(70);
    ap_done[2] = 1'b1;
    expect_rec(2, 5, 65, 0, 72);
    tick();
    ap_done[2] = 1'b0;
    check_sb_empty("deadlock");
    checks++;
`ifdef MONITOR_DEADLOCK_EN
    if (deadlock !== 4'b0100) begin errors++; $display("FAIL deadlock_sticky got %b required 0100", deadlock); end
`else
    if (deadlock !== 4'b0000) begin errors++; $display("FAIL deadlock_after got %b required 0000", deadlock); end
`endif
  endtask

  task automatic test_reset_midflight();
    do_reset();
    wait_ts(5);
    ap_start[3] = 1'b1;
    tick();
    ap_start[3] = 1'b0;
    wait_ts(8);
    ap_done[3] = 1'b1;
    tick();
    ap_done[3] = 1'b0;
    do_reset();
    wait_ts(1);
    checks++;
    if (rec_valid !== 1'b0) begin errors++; $display("FAIL midflight_rec_valid got %0b required 0", rec_valid); end
    wait_ts(20);
    check_sb_empty("midflight");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_done_wait();
    test_all_channels();
    test_overflow();
    test_deadlock();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule
